// File: rtl/controle_valvula_agua.sv
// Motorised water-valve actuator: debounced S request, limit-switch feedback, travel timeout,
// minimum open time, latched fault. Define OPEN_COUNT_EN to build the completed-opening counter.
module controle_valvula_agua #(
    parameter int DEB_CYCLES      = 4,
    parameter int TRAVEL_TIMEOUT  = 1000,
    parameter int MIN_OPEN_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_req,
    input  logic        fb_open,
    input  logic        fb_closed,
    input  logic        fault_clr,
    output logic        valve_cmd_open,
    output logic        valve_cmd_close,
    output logic        valve_is_open,
    output logic        fault,
    output logic [2:0]  state,
    output logic [15:0] open_count
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TRAVEL_TIMEOUT + 1);
    localparam int MW = $clog2(MIN_OPEN_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TIMEOUT - 1);
    localparam logic [MW-1:0] MIN_SAT     = MW'(MIN_OPEN_CYCLES);

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    logic [2:0]    r_meta;
    logic [2:0]    r_sync;
    logic          w_s_sync;
    logic          w_fbo_s;
    logic          w_fbc_s;
    logic [DW-1:0] r_deb_cnt;
    logic          r_req_f;
    logic [TW-1:0] r_travel;
    logic [MW-1:0] r_min;
    state_t        r_state;
    state_t        w_state_nxt;

    // Bit order: {fb_closed, fb_open, s_req}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {fb_closed, fb_open, s_req};
            r_sync <= r_meta;
        end
    end

    assign w_s_sync = r_sync[0];
    assign w_fbo_s  = r_sync[1];
    assign w_fbc_s  = r_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_cnt <= '0;
            r_req_f   <= 1'b0;
        end else if (w_s_sync == r_req_f) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_req_f   <= w_s_sync;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLOSED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Contradictory limit switches override every other transition.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state != ST_FAULT && w_fbo_s && w_fbc_s) begin
            w_state_nxt = ST_FAULT;
        end else begin
            case (r_state)
                ST_CLOSED: begin
                    if (r_req_f) w_state_nxt = ST_OPENING;
                end
                ST_OPENING: begin
                    if (w_fbo_s)                       w_state_nxt = ST_OPEN;
                    else if (r_travel == TRAVEL_LAST)  w_state_nxt = ST_FAULT;
                end
                ST_OPEN: begin
                    if (r_min == MIN_SAT && !r_req_f)  w_state_nxt = ST_CLOSING;
                end
                ST_CLOSING: begin
                    if (w_fbc_s)                       w_state_nxt = ST_CLOSED;
                    else if (r_travel == TRAVEL_LAST)  w_state_nxt = ST_FAULT;
                end
                ST_FAULT: begin
                    if (fault_clr && !r_req_f && !(w_fbo_s && w_fbc_s)) w_state_nxt = ST_CLOSING;
                end
                default: w_state_nxt = ST_FAULT;
            endcase
        end
    end

    // Both timers restart on every state change, so each entry begins counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_travel <= '0;
            r_min    <= '0;
        end else if (w_state_nxt != r_state) begin
            r_travel <= '0;
            r_min    <= '0;
        end else begin
            if (r_state == ST_OPENING || r_state == ST_CLOSING) r_travel <= r_travel + TW'(1);
            if (r_state == ST_OPEN && r_min != MIN_SAT)         r_min    <= r_min + MW'(1);
        end
    end

    assign state           = r_state;
    assign valve_cmd_open  = (r_state == ST_OPENING);
    assign valve_cmd_close = (r_state == ST_CLOSING);
    assign valve_is_open   = (r_state == ST_OPEN);
    assign fault           = (r_state == ST_FAULT);

`ifdef OPEN_COUNT_EN
    logic        w_open_done;
    logic [15:0] r_open_count;

    assign w_open_done = (r_state == ST_OPENING) && (w_state_nxt == ST_OPEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_open_count <= '0;
        end else if (w_open_done && r_open_count != 16'hFFFF) begin
            r_open_count <= r_open_count + 16'd1;
        end
    end

    assign open_count = r_open_count;
`else
    assign open_count = 16'h0000;
`endif
endmodule

// File: tb/tb_controle_valvula_agua.sv
// Bench for controle_valvula_agua: timestamp/history reference model checked every cycle,
// a hand-derived vector table, and randomized traffic through a simple valve plant.
module tb_controle_valvula_agua;
    localparam int DEB  = 4;
    localparam int TT   = 20;
    localparam int MINO = 50;
    localparam int QMAX = DEB + 4;
`ifdef OPEN_COUNT_EN
    localparam logic [15:0] EXP_ONE = 16'd1;
`else
    localparam logic [15:0] EXP_ONE = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s_req = 1'b0;
    logic        fb_open = 1'b0;
    logic        fb_closed = 1'b0;
    logic        fault_clr = 1'b0;
    logic        valve_cmd_open;
    logic        valve_cmd_close;
    logic        valve_is_open;
    logic        fault;
    logic [2:0]  state;
    logic [15:0] open_count;

    controle_valvula_agua #(
        .DEB_CYCLES(DEB), .TRAVEL_TIMEOUT(TT), .MIN_OPEN_CYCLES(MINO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_req(s_req), .fb_open(fb_open), .fb_closed(fb_closed),
        .fault_clr(fault_clr), .valve_cmd_open(valve_cmd_open), .valve_cmd_close(valve_cmd_close),
        .valve_is_open(valve_is_open), .fault(fault), .state(state), .open_count(open_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: raw-input history queues and state-entry timestamps.
    int m_st, m_enter, m_n, m_opens;
    bit m_reqf;
    bit q_s[$], q_o[$], q_c[$];

    task automatic model_reset();
        m_st = 0; m_enter = 0; m_n = 0; m_opens = 0; m_reqf = 1'b0;
        q_s.delete(); q_o.delete(); q_c.delete();
        for (int i = 0; i < QMAX; i++) begin
            q_s.push_back(1'b0); q_o.push_back(1'b0); q_c.push_back(1'b0);
        end
    endtask

    task automatic model_step();
        bit so, sc, flip;
        int nxt;
        m_n++;
        q_s.push_back(s_req); q_o.push_back(fb_open); q_c.push_back(fb_closed);
        if (q_s.size() > QMAX) begin
            void'(q_s.pop_front()); void'(q_o.pop_front()); void'(q_c.pop_front());
        end
        so  = q_o[q_o.size() - 3];
        sc  = q_c[q_c.size() - 3];
        nxt = m_st;
        if (m_st != 4 && so && sc) nxt = 4;
        else begin
            case (m_st)
                0: if (m_reqf) nxt = 1;
                1: begin
                    if (so) begin
                        nxt = 2;
                        if (m_opens < 65535) m_opens++;
                    end else if (m_n - m_enter == TT) nxt = 4;
                end
                2: if (m_n - m_enter > MINO && !m_reqf) nxt = 3;
                3: begin
                    if (sc) nxt = 0;
                    else if (m_n - m_enter == TT) nxt = 4;
                end
                4: if (fault_clr && !m_reqf && !(so && sc)) nxt = 3;
                default: nxt = 4;
            endcase
        end
        if (nxt != m_st) m_enter = m_n;
        m_st = nxt;
        flip = 1'b1;
        for (int k = 0; k < DEB; k++) if (q_s[q_s.size() - 3 - k] == m_reqf) flip = 1'b0;
        if (flip) m_reqf = !m_reqf;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    function automatic logic [15:0] exp_cnt();
`ifdef OPEN_COUNT_EN
        return 16'(m_opens);
`else
        return 16'h0000;
`endif
    endfunction

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model",
                {9'd0, state, valve_cmd_open, valve_cmd_close, valve_is_open, fault, open_count},
                {9'd0, 3'(m_st), m_st == 1, m_st == 3, m_st == 2, m_st == 4, exp_cnt()});
            chk("cmd_exclusive", 32'(valve_cmd_open & valve_cmd_close), 32'd0);
        end
    end

    typedef struct {
        bit         s, fo, fc, clr;
        int         n;
        logic [2:0] st;
        logic [3:0] outs;   // {cmd_open, cmd_close, is_open, fault}
    } vec_t;
    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int hold, tcnt, target, prev, pos;
        bit glitch;
        model_reset();
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outs", 32'({valve_cmd_open, valve_cmd_close, valve_is_open, fault}), 32'd0);
        chk("reset_count", 32'(open_count), 32'd0);

        // Release with s_req held high: open command on the 7th edge.
        rst_n = 1'b1; s_req = 1'b1;
        repeat (6) @(negedge clk);
        chk("cmd_open_edge6", 32'(valve_cmd_open), 32'd0);
        @(negedge clk);
        chk("cmd_open_edge7", 32'(valve_cmd_open), 32'd1);
        fb_open = 1'b1;
        repeat (2) @(negedge clk);
        chk("opening_edge9", 32'(state), 32'd1);
        @(negedge clk);
        chk("is_open_edge10", 32'(valve_is_open), 32'd1);
        chk("open_count_1", 32'(open_count), 32'(EXP_ONE));

        // Request drops early in OPEN: closing waits out the minimum open time.
        s_req = 1'b0; fb_open = 1'b0;
        w = 0;
        while (state != 3'd3 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("closing_wait", 32'(w), 32'(MINO + 1));
        chk("closing_cmd", 32'(valve_cmd_close), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cmd_close", 32'(valve_cmd_close), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_count", 32'(open_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back('{0, 0, 0, 0,  2, 3'd0, 4'b0000});
        tbl.push_back('{1, 0, 0, 0,  3, 3'd0, 4'b0000});
        tbl.push_back('{0, 0, 0, 0,  8, 3'd0, 4'b0000});
        tbl.push_back('{1, 0, 0, 0,  6, 3'd0, 4'b0000});
        tbl.push_back('{1, 0, 0, 0,  1, 3'd1, 4'b1000});
        tbl.push_back('{1, 0, 0, 0, 10, 3'd1, 4'b1000});
        tbl.push_back('{1, 1, 0, 0,  2, 3'd1, 4'b1000});
        tbl.push_back('{1, 1, 0, 0,  1, 3'd2, 4'b0010});
        tbl.push_back('{0, 1, 0, 0,  6, 3'd2, 4'b0010});
        tbl.push_back('{0, 1, 0, 0, 44, 3'd2, 4'b0010});
        tbl.push_back('{0, 0, 0, 0,  1, 3'd3, 4'b0100});
        tbl.push_back('{0, 0, 1, 0,  2, 3'd3, 4'b0100});
        tbl.push_back('{0, 0, 1, 0,  1, 3'd0, 4'b0000});
        tbl.push_back('{1, 0, 0, 0,  7, 3'd1, 4'b1000});
        tbl.push_back('{1, 0, 0, 0, 19, 3'd1, 4'b1000});
        tbl.push_back('{1, 0, 0, 0,  1, 3'd4, 4'b0001});
        tbl.push_back('{1, 0, 0, 1,  1, 3'd4, 4'b0001});
        tbl.push_back('{0, 0, 0, 0,  6, 3'd4, 4'b0001});
        tbl.push_back('{0, 0, 0, 1,  1, 3'd3, 4'b0100});
        tbl.push_back('{0, 0, 1, 0,  3, 3'd0, 4'b0000});
        tbl.push_back('{1, 0, 0, 0,  7, 3'd1, 4'b1000});
        tbl.push_back('{1, 1, 0, 0,  3, 3'd2, 4'b0010});
        tbl.push_back('{1, 1, 1, 0,  2, 3'd2, 4'b0010});
        tbl.push_back('{1, 1, 1, 0,  1, 3'd4, 4'b0001});
        tbl.push_back('{0, 1, 1, 0,  6, 3'd4, 4'b0001});
        tbl.push_back('{0, 1, 1, 1,  1, 3'd4, 4'b0001});
        tbl.push_back('{0, 0, 1, 0,  2, 3'd4, 4'b0001});
        tbl.push_back('{0, 0, 1, 1,  1, 3'd3, 4'b0100});
        tbl.push_back('{0, 0, 1, 0,  1, 3'd0, 4'b0000});

        foreach (tbl[i]) begin
            s_req = tbl[i].s; fb_open = tbl[i].fo; fb_closed = tbl[i].fc; fault_clr = tbl[i].clr;
            for (int c = 0; c < tbl[i].n; c++) begin
                @(negedge clk);
                fault_clr = 1'b0;
            end
            chk($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("row%0d_outs", i),
                32'({valve_cmd_open, valve_cmd_close, valve_is_open, fault}), 32'(tbl[i].outs));
        end

        // Randomized traffic against a valve that travels in a random number of cycles.
        @(negedge clk);
        s_req = 1'b0; fb_open = 1'b0; fb_closed = 1'b1; fault_clr = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hold = 0; tcnt = 0; target = 1; prev = 0; pos = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (hold == 0) begin
                s_req = ~s_req;
                hold = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5))
                                                   : int'($urandom_range(20, 300));
            end else begin
                hold--;
            end
            if (m_st != prev) begin
                tcnt = 0;
                target = int'($urandom_range(1, 24));
            end else begin
                tcnt++;
            end
            if (m_st == 1)      pos = (tcnt >= target) ? 1 : 2;
            else if (m_st == 3) pos = (tcnt >= target) ? 0 : 2;
            glitch = ($urandom_range(0, 299) == 0);
            fb_open   = glitch || (pos == 1);
            fb_closed = glitch || (pos == 0);
            fault_clr = ($urandom_range(0, 11) == 0);
            prev = m_st;
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
